// File: rtl/normalizer_pkg.sv
// Shared types and constants for the single-precision min-max normalizer.
package normalizer_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    StIdle,
    StSubNum,
    StSubDen,
    StDivInit,
    StDiv,
    StRound,
    StDone
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W:0]   mant;     // hidden bit included
    logic             is_zero;  // true zero or flushed subnormal
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  function automatic fp_unpacked_t fp_unpack(input logic [31:0] f);
    fp_unpacked_t u;
    u.sign    = f[31];
    u.expo    = f[30:23];
    u.is_zero = (f[30:23] == 8'h00);
    u.is_inf  = (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    u.is_nan  = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    u.mant    = u.is_zero ? 24'd0 : {1'b1, f[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_sub.sv
// Combinational single-precision a - b, round-to-nearest-even, subnormals flushed to zero.
module fp_sub
  import normalizer_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  fp_unpacked_t ua, ub;
  logic                a_big, big_sign, sml_sign, round_up;
  logic [EXP_W-1:0]    big_exp, sml_exp, shamt;
  logic [MAN_W:0]      big_m, sml_m;
  logic [49:0]         sml_sh;
  logic [26:0]         big_x, sml_x, norm;
  logic [27:0]         sum;
  logic [4:0]          lz;
  logic [24:0]         rnd;
  logic signed [9:0]   res_exp;

  assign ua = fp_unpack(a_i);
  assign ub = fp_unpack(b_i);

  always_comb begin
    // Subtraction is addition of b with its sign flipped; order operands by magnitude.
    a_big    = {ua.expo, ua.mant} >= {ub.expo, ub.mant};
    big_sign = a_big ? ua.sign : ~ub.sign;
    sml_sign = a_big ? ~ub.sign : ua.sign;
    big_exp  = a_big ? ua.expo : ub.expo;
    sml_exp  = a_big ? ub.expo : ua.expo;
    big_m    = a_big ? ua.mant : ub.mant;
    sml_m    = a_big ? ub.mant : ua.mant;
    shamt    = big_exp - sml_exp;

    // Three extra bits below the LSB: guard, round, sticky.
    big_x  = {big_m, 3'b000};
    sml_sh = {sml_m, 26'd0} >> shamt;
    if (shamt > 8'd49) begin
      sml_x = 27'd1;
    end else begin
      sml_x = {sml_sh[49:24], |sml_sh[23:0]};
    end

    res_exp = signed'({2'b00, big_exp});
    lz      = 5'd27;
    norm    = '0;
    if (big_sign == sml_sign) begin
      sum = {1'b0, big_x} + {1'b0, sml_x};
      if (sum[27]) begin
        norm    = {sum[27:2], sum[1] | sum[0]};
        res_exp = res_exp + 10'sd1;
      end else begin
        norm = sum[26:0];
      end
    end else begin
      sum = {1'b0, big_x - sml_x};
      for (int i = 0; i <= 26; i++) begin
        if (sum[i]) lz = 5'(26 - i);
      end
      norm    = sum[26:0] << lz;
      res_exp = res_exp - signed'({5'b00000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (rnd[24]) begin
      rnd     = rnd >> 1;
      res_exp = res_exp + 10'sd1;
    end

    y_o = 32'd0;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign == ub.sign))) begin
      y_o = QNAN;
    end else if (ua.is_inf) begin
      y_o = {ua.sign, POS_INF[30:0]};
    end else if (ub.is_inf) begin
      y_o = {~ub.sign, POS_INF[30:0]};
    end else if (ua.is_zero && ub.is_zero) begin
      y_o = {ua.sign & ~ub.sign, 31'd0};
    end else if (ua.is_zero) begin
      y_o = {~ub.sign, b_i[30:0]};
    end else if (ub.is_zero) begin
      y_o = a_i;
    end else if (sum == 28'd0) begin
      y_o = 32'd0;  // exact cancellation is +0 under RNE
    end else if (res_exp <= 10'sd0) begin
      y_o = {big_sign, 31'd0};
    end else if (res_exp >= 10'sd255) begin
      y_o = {big_sign, POS_INF[30:0]};
    end else begin
      y_o = {big_sign, res_exp[7:0], rnd[22:0]};
    end
  end

endmodule

// File: rtl/normalizer.sv
// Multi-cycle min-max normalizer: out_data = (in_data - min) / (max - min), single precision.
module normalizer
  import normalizer_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] max,
  input  logic [31:0] min,
  input  logic [31:0] in_data,
  output logic        valid,
  output logic        busy,
  output logic [31:0] out_data
);

  state_e                state_q, state_d;
  logic [31:0]           max_q, max_d, min_q, min_d, in_q, in_d;
  logic [31:0]           num_q, num_d, den_q, den_d, out_q, out_d;
  logic [31:0]           spec_res_q, spec_res_d;
  logic                  special_q, special_d, sign_q, sign_d;
  logic signed [9:0]     exp_q, exp_d;
  logic [MAN_W:0]        dm_q, dm_d;
  logic [24:0]           rem_q, rem_d;
  logic [DIV_ITERS-1:0]  quo_q, quo_d;
  logic [4:0]            cnt_q, cnt_d;

  logic [31:0]           sub_a, sub_y;
  fp_unpacked_t          un, ud;
  logic                  adj, ge, rup;
  logic [24:0]           num_al, rem_sh;
  logic [24:0]           qm;
  logic signed [9:0]     fin_exp;
  logic [31:0]           rounded;

  // One subtractor serves both num = in - min and den = max - min.
  assign sub_a = (state_q == StSubNum) ? in_q : max_q;

  fp_sub u_fp_sub (
    .a_i (sub_a),
    .b_i (min_q),
    .y_o (sub_y)
  );

  assign un = fp_unpack(num_q);
  assign ud = fp_unpack(den_q);

  assign valid    = (state_q == StDone);
  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign out_data = out_q;

  always_comb begin
    // Alignment guarantees the leading quotient bit is 1, so DIV_INIT produces it.
    adj    = un.mant < ud.mant;
    num_al = adj ? {un.mant, 1'b0} : {1'b0, un.mant};
    rem_sh = {rem_q[23:0], 1'b0};
    ge     = rem_sh >= {1'b0, dm_q};

    rup     = quo_q[DIV_ITERS-25] & (quo_q[DIV_ITERS-26] | (|rem_q) | quo_q[DIV_ITERS-24]);
    qm      = {1'b0, quo_q[DIV_ITERS-1 -: 24]} + {24'd0, rup};
    fin_exp = exp_q + (qm[24] ? 10'sd1 : 10'sd0);
    if (fin_exp >= 10'sd255) begin
      rounded = {sign_q, POS_INF[30:0]};
    end else if (fin_exp <= 10'sd0) begin
      rounded = {sign_q, 31'd0};
    end else begin
      rounded = {sign_q, fin_exp[7:0], qm[22:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    min_d      = min_q;
    in_d       = in_q;
    num_d      = num_q;
    den_d      = den_q;
    out_d      = out_q;
    spec_res_d = spec_res_q;
    special_d  = special_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    dm_d       = dm_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          max_d   = max;
          min_d   = min;
          in_d    = in_data;
          state_d = StSubNum;
        end
      end
      StSubNum: begin
        num_d   = sub_y;
        state_d = StSubDen;
      end
      StSubDen: begin
        den_d   = sub_y;
        state_d = StDivInit;
      end
      StDivInit: begin
        sign_d     = un.sign ^ ud.sign;
        special_d  = 1'b1;
        spec_res_d = 32'd0;
        if (un.is_nan || ud.is_nan || (un.is_zero && ud.is_zero)) begin
          spec_res_d = QNAN;
        end else if (ud.is_zero || un.is_inf) begin
          spec_res_d = {un.sign ^ ud.sign, POS_INF[30:0]};
        end else if (un.is_zero || ud.is_inf) begin
          spec_res_d = {un.sign ^ ud.sign, 31'd0};
        end else begin
          special_d = 1'b0;
        end
        exp_d = signed'({2'b00, un.expo}) - signed'({2'b00, ud.expo})
              + signed'(10'(BIAS)) - (adj ? 10'sd1 : 10'sd0);
        dm_d    = ud.mant;
        rem_d   = num_al - {1'b0, ud.mant};
        quo_d   = DIV_ITERS'(1);
        cnt_d   = 5'd0;
        state_d = StDiv;
      end
      StDiv: begin
        rem_d = ge ? (rem_sh - {1'b0, dm_q}) : rem_sh;
        quo_d = {quo_q[DIV_ITERS-2:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 2)) state_d = StRound;
      end
      StRound: begin
        out_d   = special_q ? spec_res_q : rounded;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      max_q      <= '0;
      min_q      <= '0;
      in_q       <= '0;
      num_q      <= '0;
      den_q      <= '0;
      out_q      <= '0;
      spec_res_q <= '0;
      special_q  <= 1'b0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      dm_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      max_q      <= max_d;
      min_q      <= min_d;
      in_q       <= in_d;
      num_q      <= num_d;
      den_q      <= den_d;
      out_q      <= out_d;
      spec_res_q <= spec_res_d;
      special_q  <= special_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      dm_q       <= dm_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Directed bench for normalizer: results, fixed latency, ignored restart and mid-op reset.
module tb_normalizer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] max;
  logic [31:0] min;
  logic [31:0] in_data;
  logic        valid;
  logic        busy;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;

  normalizer #(
    .DIV_ITERS (26)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .max      (max),
    .min      (min),
    .in_data  (in_data),
    .valid    (valid),
    .busy     (busy),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is 1 time unit after a rising edge. Start is sampled by the next edge (edge 0).
  task automatic run_op(input string tag, input logic [31:0] mx, input logic [31:0] mn,
                        input logic [31:0] din, input logic [31:0] exp_res, input bit poke);
    int early;
    int pulses;
    int idle_cycles;
    max     = mx;
    min     = mn;
    in_data = din;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s busy_at_1", tag), {31'd0, busy}, 32'd1);
    early = 0;
    for (int k = 1; k <= 28; k++) begin
      if (poke && k == 5) begin
        max     = 32'h4a3d3580;
        min     = 32'h47629000;
        in_data = 32'h490ed280;
        start   = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (valid || !busy) early++;
    end
    chk($sformatf("%s early_valid_or_idle", tag), early, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("%s valid_at_30", tag), {31'd0, valid}, 32'd1);
    chk($sformatf("%s busy_at_30", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s out_data", tag), out_data, exp_res);
    @(posedge clk); #1;
    chk($sformatf("%s valid_drop", tag), {31'd0, valid}, 32'd0);
    pulses      = 0;
    idle_cycles = poke ? 35 : 3;
    for (int k = 0; k < idle_cycles; k++) begin
      @(posedge clk); #1;
      if (valid || busy) pulses++;
    end
    chk($sformatf("%s no_extra_activity", tag), pulses, 32'd0);
    chk($sformatf("%s out_held", tag), out_data, exp_res);
  endtask

  initial begin
    int pulses;
    rst     = 1'b1;
    start   = 1'b0;
    max     = 32'd0;
    min     = 32'd0;
    in_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("vec1", 32'h41733333, 32'h40733333, 32'h4111eb85, 32'h3EEEEEEF, 1'b0);
    run_op("vec2", 32'h4a3d3580, 32'h47629000, 32'h490ed280, 32'h3E31662A, 1'b0);

    run_op("at_min", 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0);
    run_op("at_max", 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0);
    run_op("below_min", 32'h40000000, 32'h3F800000, 32'h3F000000, 32'hBF000000, 1'b0);

    run_op("den0_inf", 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h7F800000, 1'b0);
    run_op("den0_num0", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b0);
    run_op("den0_nan", 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b0);

    run_op("restart_ignored", 32'h41733333, 32'h40733333, 32'h4111eb85, 32'h3EEEEEEF, 1'b1);

    // Reset sampled at edge 10 of an operation.
    max     = 32'h40000000;
    min     = 32'h3F800000;
    in_data = 32'h3F000000;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset valid", {31'd0, valid}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset out_data", out_data, 32'd0);
    pulses = 0;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      if (valid || busy) pulses++;
    end
    chk("midreset no_valid_after", pulses, 32'd0);

    run_op("after_reset", 32'h41733333, 32'h40733333, 32'h4111eb85, 32'h3EEEEEEF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
